// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA bus master that halts the CPU through rdy and copies one page to DEST_ADDR.
// Build option: define OAM_DMA_ALIGN_EN to insert the parity-dependent ALIGN2 dummy cycle.
module oam_dma_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR  = 16'h2004,
  parameter int unsigned           XFER_LEN   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic                  cpu_r_w_n,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  rdy,
  output logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [REG_WIDTH-1:0]  dma_dout,
  output logic                  dma_r_w_n,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned OFS_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_ALIGN  = 3'd2,
    S_ALIGN2 = 3'd3,
    S_READ   = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [REG_WIDTH-1:0]    page_q;
  logic [REG_WIDTH-1:0]    page_d;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic [CNT_W-1:0]        count_inc_c;
  logic                    trig_c;
  logic                    last_c;
  logic                    align_c;

  logic                    rdy_d;
  logic                    bus_grant_d;
  logic [ADDR_WIDTH-1:0]   dma_addr_d;
  logic [REG_WIDTH-1:0]    dma_dout_d;
  logic                    dma_r_w_n_d;
  logic                    busy_d;
  logic                    done_d;

  // Trigger only counts while idle; later writes to TRIG_ADDR are ignored.
  assign trig_c      = (state_q == S_IDLE) && !cpu_r_w_n && (cpu_addr == TRIG_ADDR);
  assign count_inc_c = count_q + CNT_W'(1);
  assign last_c      = (count_inc_c == CNT_W'(XFER_LEN));

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;

  // Free-running cycle parity used to align the first read to the CPU's get/put phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ~parity_q;
  end

  assign align_c = parity_q;
`else
  assign align_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; HALT waits out CPU write cycles because the 6502 ignores rdy on writes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (trig_c)    state_d = S_HALT;
      S_HALT:   if (cpu_r_w_n) state_d = S_ALIGN;
      S_ALIGN:  state_d = align_c ? S_ALIGN2 : S_READ;
      S_ALIGN2: state_d = S_READ;
      S_READ:   state_d = S_WRITE;
      S_WRITE:  state_d = last_c ? S_DONE : S_READ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath decode from the next state so every output leaves a flop.
  always_comb begin
    page_d      = page_q;
    count_d     = count_q;
    rdy_d       = 1'b1;
    bus_grant_d = 1'b0;
    dma_addr_d  = '0;
    dma_dout_d  = dma_dout;
    dma_r_w_n_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    if (trig_c) begin
      page_d  = cpu_dout;
      count_d = '0;
    end else if (state_q == S_WRITE) begin
      count_d = count_inc_c;
    end

    if (state_q == S_READ) dma_dout_d = mem_dout;

    unique case (state_d)
      S_IDLE: begin
        rdy_d = 1'b1;
      end
      S_HALT, S_ALIGN, S_ALIGN2: begin
        rdy_d  = 1'b0;
        busy_d = 1'b1;
      end
      S_READ: begin
        rdy_d       = 1'b0;
        busy_d      = 1'b1;
        bus_grant_d = 1'b1;
        // Source offset is count[7:0] only, so the read never leaves the page.
        dma_addr_d  = ADDR_WIDTH'({page_d, count_d[OFS_W-1:0]});
      end
      S_WRITE: begin
        rdy_d       = 1'b0;
        busy_d      = 1'b1;
        bus_grant_d = 1'b1;
        dma_r_w_n_d = 1'b0;
        dma_addr_d  = DEST_ADDR;
      end
      S_DONE: begin
        rdy_d  = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        rdy_d = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q    <= '0;
      count_q   <= '0;
      rdy       <= 1'b1;
      bus_grant <= 1'b0;
      dma_addr  <= '0;
      dma_dout  <= '0;
      dma_r_w_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      page_q    <= page_d;
      count_q   <= count_d;
      rdy       <= rdy_d;
      bus_grant <= bus_grant_d;
      dma_addr  <= dma_addr_d;
      dma_dout  <= dma_dout_d;
      dma_r_w_n <= dma_r_w_n_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench; stimulus queues the expected bus cycles, a negedge monitor checks them.
module tb_oam_dma_ctrl;

  localparam int unsigned N    = 256;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_w_n;
  logic [7:0]  mem_dout;
  logic        rdy;
  logic        bus_grant;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_r_w_n;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } bus_t;

  bus_t        exp_q[$];
  logic [7:0]  mem [0:65535];
  int          n_tests;
  int          n_fail;
  int          done_cnt;
  int          writes_seen;
  int          halt_run;
  int          last_halt;
  bit          prev_done;
  int          ecount;

  oam_dma_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_r_w_n (cpu_r_w_n),
    .mem_dout  (mem_dout),
    .rdy       (rdy),
    .bus_grant (bus_grant),
    .dma_addr  (dma_addr),
    .dma_dout  (dma_dout),
    .dma_r_w_n (dma_r_w_n),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[bus_grant ? dma_addr : cpu_addr];

  // Cycle count since reset; its LSB is the alignment parity seen in ALIGN.
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every granted bus cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      halt_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus_grant) begin
        check("rdy_with_grant", 32'(rdy), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_bus_cycle: addr %0h rw %0b with no expected cycle", dma_addr, dma_r_w_n);
        end else begin
          bus_t e;
          e = exp_q.pop_front();
          check("bus_addr", 32'(dma_addr), 32'(e.addr));
          check("bus_rw", 32'(dma_r_w_n), 32'(e.rw));
          if (!e.rw) begin
            check("bus_data", 32'(dma_dout), 32'(e.data));
            writes_seen++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
      end
      prev_done = done;
      if (!rdy) halt_run++;
      else if (halt_run != 0) begin
        last_halt = halt_run;
        halt_run  = 0;
      end
    end
  end

  task automatic start_dma(input logic [7:0] page, input int w, input bit pat, output int exp_halt);
    int align;
    for (int i = 0; i < N; i++) begin
      bus_t rd;
      bus_t wr;
      mem[{page, 8'(i)}] = pat ? (8'(i) ^ 8'h5A) : 8'($urandom);
      rd.addr = {page, 8'(i)};
      rd.rw   = 1'b1;
      rd.data = 8'h00;
      wr.addr = DEST;
      wr.rw   = 1'b0;
      wr.data = mem[{page, 8'(i)}];
      exp_q.push_back(rd);
      exp_q.push_back(wr);
    end
    @(posedge clk); #1;
    cpu_addr  = TRIG;
    cpu_dout  = page;
    cpu_r_w_n = 1'b0;
    @(posedge clk); #1;
    check("halt_rdy", 32'(rdy), 32'd0);
    check("halt_busy", 32'(busy), 32'd1);
    for (int j = 0; j < w; j++) begin
      cpu_addr  = 16'h0100 | 16'(8'hFD - 8'(j));
      cpu_dout  = 8'($urandom);
      cpu_r_w_n = 1'b0;
      check("no_grant_in_cpu_write", 32'(bus_grant), 32'd0);
      @(posedge clk); #1;
    end
    cpu_addr  = 16'(16'h8000 + 16'($urandom_range(0, 255)));
    cpu_r_w_n = 1'b1;
    @(posedge clk); #1;
`ifdef OAM_DMA_ALIGN_EN
    align = ecount % 2;
`else
    align = 0;
`endif
    // HALT (trigger cycle + write-wait), ALIGN, optional ALIGN2, then read/write per byte.
    exp_halt = 1 + w + 1 + align + 2 * N;
  endtask

  task automatic finish_dma(input int exp_halt, input int d0, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done pulse within 3000 cycles", name);
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_halt_len"}, 32'(last_halt), 32'(exp_halt));
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_rdy_after"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    int eh;
    int d0;
    int wr0;
    bit hit;
    logic [7:0] pg;

    n_tests = 0; n_fail = 0; done_cnt = 0; writes_seen = 0;
    halt_run = 0; last_halt = 0; prev_done = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a ^ (a >> 8));
    reset = 1'b1; cpu_addr = '0; cpu_dout = '0; cpu_r_w_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_grant", 32'(bus_grant), 32'd0);
    check("rst_addr", 32'(dma_addr), 32'd0);
    check("rst_dout", 32'(dma_dout), 32'd0);
    check("rst_rw", 32'(dma_r_w_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Page $03 filled with i^5A, no write-wait.
    d0 = done_cnt; start_dma(8'h03, 0, 1'b1, eh); finish_dma(eh, d0, "pattern");

    // BRK-style push sequence after the trigger keeps HALT waiting.
    d0 = done_cnt; start_dma(8'h42, 3, 1'b0, eh); finish_dma(eh, d0, "brk_wait");

    // Last page must not wrap to $0000.
    d0 = done_cnt; start_dma(8'hFF, 0, 1'b0, eh); finish_dma(eh, d0, "page_ff");

    // Random pages and write-waits exercise both parities.
    for (int k = 0; k < 4; k++) begin
      pg = 8'($urandom);
      d0 = done_cnt; start_dma(pg, int'($urandom_range(0, 3)), 1'b0, eh); finish_dma(eh, d0, "random");
    end

    // Second trigger write mid-transfer is ignored.
    pg = 8'h21;
    d0 = done_cnt; start_dma(pg, 1, 1'b0, eh);
    repeat (40) @(posedge clk);
    #1;
    cpu_addr = TRIG; cpu_dout = 8'h77; cpu_r_w_n = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_r_w_n = 1'b1;
    finish_dma(eh, d0, "retrigger");

    // Reset after 100 bytes: immediate idle, no done pulse.
    d0 = done_cnt; start_dma(8'h05, 0, 1'b0, eh);
    wr0 = writes_seen; hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (writes_seen - wr0 >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL reset_wait_timeout: only %0d bytes written", writes_seen - wr0);
    end
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_grant", 32'(bus_grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rw", 32'(dma_r_w_n), 32'd1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    d0 = done_cnt; start_dma(8'h06, 2, 1'b0, eh); finish_dma(eh, d0, "after_reset");

    // CPU write to DEST_ADDR while idle passes straight through.
    @(posedge clk); #1;
    cpu_addr = DEST; cpu_dout = 8'hA5; cpu_r_w_n = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_r_w_n = 1'b1;
    check("dest_idle_grant", 32'(bus_grant), 32'd0);
    check("dest_idle_rdy", 32'(rdy), 32'd1);
    check("dest_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("dest_idle_grant_later", 32'(bus_grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
